lcd_reader: RTL and testbench

Read-side controller for the HD44780-class character LCD bus. The setup and character-generator blocks only write to the panel; this block performs timed read cycles on the same bus. It reads either the busy flag and address counter (RS=0) or DDRAM/CGRAM data (RS=1). In poll mode it repeats busy-flag reads until the panel reports ready. It sits beside the write path at the top level, which releases the data bus and selects this block's `ctrl` whenever `busRead`=1.

---
 rtl/lcd_pkg.sv | 44 ++++
 rtl/lcd_phase_timer.sv | 27 ++
 rtl/lcd_reader.sv | 116 +++++++++++
 tb/tb_lcd_reader.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-class LCD bus blocks.
// Holds control bit positions, default bus timing and the reader's state set.
package lcd_pkg;

    localparam int CTRL_E  = 2;
    localparam int CTRL_RW = 1;
    localparam int CTRL_RS = 0;
    localparam int BF_BIT  = 7;

    localparam int DEF_T_AS     = 3;
    localparam int DEF_T_EH     = 12;
    localparam int DEF_T_H      = 2;
    localparam int DEF_T_GAP    = 8;
    localparam int DEF_POLL_MAX = 1000;

    typedef enum logic [2:0] {
        RD_IDLE,
        RD_SETUP,
        RD_EHIGH,
        RD_HOLD,
        RD_GAP,
        RD_DONE
    } rd_state_t;

    // Bus control word {E, RW, RS} driven while the reader sits in a given state.
    function automatic logic [2:0] rd_ctrl(input rd_state_t st, input logic rs);
        logic [2:0] c;
        c = '0;
        case (st)
            RD_SETUP, RD_HOLD: begin
                c[CTRL_RW] = 1'b1;
                c[CTRL_RS] = rs;
            end
            RD_EHIGH: begin
                c[CTRL_E]  = 1'b1;
                c[CTRL_RW] = 1'b1;
                c[CTRL_RS] = rs;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable 8-bit down-counter timing each bus phase.
// Loaded with (phase length - 1) on state entry; zero marks the last cycle of the phase.
module lcd_phase_timer (
    input  logic       CLK,
    input  logic       RST,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       zero
);

    logic [7:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its inputs, independent of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt <= 8'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
        end
    end

    assign zero = (cnt == 8'd0);

endmodule

// File: rtl/lcd_reader.sv
// Timed read-cycle controller for the HD44780-class LCD bus: single busy-flag/address
// or data reads, plus busy-flag polling until the panel reports ready.
module lcd_reader
    import lcd_pkg::*;
#(
    parameter int T_AS     = DEF_T_AS,
    parameter int T_EH     = DEF_T_EH,
    parameter int T_H      = DEF_T_H,
    parameter int T_GAP    = DEF_T_GAP,
    parameter int POLL_MAX = DEF_POLL_MAX
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       req,
    input  logic       rs,
    input  logic       poll,
    input  logic [7:0] dIn,
    output logic [2:0] ctrl,
    output logic       busRead,
    output logic       busy,
    output logic [7:0] rdData,
    output logic       rdValid,
    output logic       timeout
);

    localparam logic [15:0] POLL_MAX_W = 16'(POLL_MAX);

    rd_state_t   state;
    rd_state_t   next_state;
    logic        rs_q;
    logic        poll_q;
    logic [15:0] poll_cnt;
    logic        phase_done;
    logic        timer_load;
    logic [7:0]  timer_val;
    logic        cur_rs;

    lcd_phase_timer u_timer (
        .CLK      (CLK),
        .RST      (RST),
        .load     (timer_load),
        .load_val (timer_val),
        .zero     (phase_done)
    );

    // NOTE: every variable written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        next_state = state;
        timer_val  = 8'd0;
        case (state)
            RD_IDLE:  if (req) next_state = RD_SETUP;
            RD_SETUP: if (phase_done) next_state = RD_EHIGH;
            RD_EHIGH: if (phase_done) next_state = RD_HOLD;
            RD_HOLD: begin
                if (phase_done) begin
                    if (poll_q && rdData[BF_BIT] && (poll_cnt < POLL_MAX_W))
                        next_state = RD_GAP;
                    else
                        next_state = RD_DONE;
                end
            end
            RD_GAP:   if (phase_done) next_state = RD_SETUP;
            RD_DONE:  next_state = RD_IDLE;
            default:  next_state = RD_IDLE;
        endcase

        case (next_state)
            RD_SETUP: timer_val = 8'(T_AS - 1);
            RD_EHIGH: timer_val = 8'(T_EH - 1);
            RD_HOLD:  timer_val = 8'(T_H - 1);
            RD_GAP:   timer_val = 8'(T_GAP - 1);
            default:  timer_val = 8'd0;
        endcase
    end

    assign timer_load = (next_state != state);
    // On the accepting edge rs_q is not yet loaded, so the first SETUP word uses the port.
    assign cur_rs     = (state == RD_IDLE) ? rs : rs_q;

    always_ff @(posedge CLK) begin
        state <= next_state;
        if (RST) state <= RD_IDLE;
    end

    // Outputs are registered from next_state so they line up with the state they describe.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rs_q     <= 1'b0;
            poll_q   <= 1'b0;
            poll_cnt <= 16'd0;
            rdData   <= 8'h00;
            ctrl     <= 3'b000;
            busy     <= 1'b0;
            busRead  <= 1'b0;
            rdValid  <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            if (state == RD_IDLE) begin
                rs_q     <= rs;
                poll_q   <= poll & ~rs;
                poll_cnt <= 16'd0;
            end
            if (state == RD_EHIGH && phase_done) begin
                rdData <= dIn;
                if (poll_cnt != 16'hFFFF) poll_cnt <= poll_cnt + 16'd1;
            end
            ctrl    <= rd_ctrl(next_state, cur_rs);
            busy    <= (next_state != RD_IDLE);
            busRead <= (next_state != RD_IDLE);
            rdValid <= (next_state == RD_DONE);
            timeout <= (next_state == RD_DONE) && poll_q && rdData[BF_BIT];
        end
    end

endmodule

// File: tb/tb_lcd_reader.sv
// Scoreboard bench for lcd_reader: a panel model answers reads, a spec-level model
// predicts each transaction's outcome and a monitor checks it when rdValid pulses.
module tb_lcd_reader;
    import lcd_pkg::*;

    localparam int T_AS      = 3;
    localparam int T_EH      = 12;
    localparam int T_H       = 2;
    localparam int T_GAP     = 8;
    localparam int POLL_MAX  = 4;
    localparam int READ_LEN  = T_AS + T_EH + T_H;
    localparam int POLL_STEP = T_GAP + READ_LEN;

    logic       CLK = 1'b0;
    logic       RST;
    logic       req;
    logic       rs;
    logic       poll;
    logic [7:0] dIn;
    logic [2:0] ctrl;
    logic       busRead;
    logic       busy;
    logic [7:0] rdData;
    logic       rdValid;
    logic       timeout;

    lcd_reader #(
        .T_AS     (T_AS),
        .T_EH     (T_EH),
        .T_H      (T_H),
        .T_GAP    (T_GAP),
        .POLL_MAX (POLL_MAX)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .req     (req),
        .rs      (rs),
        .poll    (poll),
        .dIn     (dIn),
        .ctrl    (ctrl),
        .busRead (busRead),
        .busy    (busy),
        .rdData  (rdData),
        .rdValid (rdValid),
        .timeout (timeout)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] data;
        logic       tmo;
        logic       rs;
        int         reads;
        int         acc;
        int         rises0;
        int         ehigh0;
        int         rshigh0;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [7:0] rd_vals[$];
    int         panel_idx = 0;
    int         e_rises = 0;
    int         e_high = 0;
    int         rs_high = 0;
    int         last_rise = 0;
    logic       e_prev = 1'b0;
    logic       cur_rs = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    function automatic logic [7:0] val_at(input int i);
        return rd_vals[(i < rd_vals.size()) ? i : rd_vals.size() - 1];
    endfunction

    // Spec-level prediction: one read, or in poll mode keep reading while BF=1, capped at POLL_MAX.
    function automatic exp_t model(input logic m_rs, input logic m_poll);
        exp_t       e;
        logic       pm;
        logic [7:0] v;
        int         r;
        pm = m_poll && !m_rs;
        r  = 1;
        if (pm) begin
            while (r < POLL_MAX) begin
                v = val_at(r - 1);
                if (!v[BF_BIT]) break;
                r++;
            end
        end
        v       = val_at(r - 1);
        e.data  = v;
        e.tmo   = pm && v[BF_BIT];
        e.rs    = m_rs;
        e.reads = r;
        e.acc   = 0;
        e.rises0 = 0;
        e.ehigh0 = 0;
        e.rshigh0 = 0;
        return e;
    endfunction

    // Panel: presents the next scripted byte on each E rise and tallies bus activity.
    always @(negedge CLK) begin
        if (ctrl[CTRL_E] && !e_prev) begin
            e_rises++;
            last_rise = cyc;
            dIn = val_at(panel_idx);
            panel_idx++;
        end
        if (ctrl[CTRL_E]) begin
            e_high++;
            check("e_high_rw_rs", 32'(ctrl), 32'({2'b11, cur_rs}));
        end
        if (ctrl[CTRL_RS]) rs_high++;
        e_prev = ctrl[CTRL_E];
    end

    always @(negedge CLK) begin
        if (rdValid) begin
            if (sb.size() == 0) begin
                check("unexpected_rdvalid", 32'(rdValid), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("rd_data", 32'(rdData), 32'(mon_e.data));
                check("timeout", 32'(timeout), 32'(mon_e.tmo));
                check("latency", 32'(cyc - mon_e.acc + 1),
                      32'(mon_e.reads * READ_LEN + (mon_e.reads - 1) * T_GAP + 1));
                check("e_pulses", 32'(e_rises - mon_e.rises0), 32'(mon_e.reads));
                check("e_high_cycles", 32'(e_high - mon_e.ehigh0), 32'(mon_e.reads * T_EH));
                check("rs_cycles", 32'(rs_high - mon_e.rshigh0),
                      32'(mon_e.rs ? mon_e.reads * READ_LEN : 0));
                check("last_e_rise", 32'(last_rise - mon_e.acc + 1),
                      32'((mon_e.reads - 1) * POLL_STEP + T_AS + 1));
                check("busy_in_done", 32'({busy, busRead}), 32'd3);
            end
        end
    end

    task automatic record_accept(input exp_t e_in);
        exp_t e;
        e         = e_in;
        e.acc     = cyc;
        e.rises0  = e_rises;
        e.ehigh0  = e_high;
        e.rshigh0 = rs_high;
        panel_idx = 0;
        sb.push_back(e);
    endtask

    task automatic start_txn(input logic t_rs, input logic t_poll);
        exp_t e;
        e = model(t_rs, t_poll);
        @(negedge CLK);
        cur_rs = t_rs;
        req    = 1'b1;
        rs     = t_rs;
        poll   = t_poll;
        @(posedge CLK);
        #1;
        record_accept(e);
        @(negedge CLK);
        req  = 1'b0;
        rs   = 1'($urandom);
        poll = 1'($urandom);
    endtask

    task automatic wait_idle(input int budget, input string name);
        for (int n = 0; n < budget; n++) begin
            @(negedge CLK);
            if (!busy) return;
        end
        check(name, 32'(busy), 32'd0);
    endtask

    initial begin
        exp_t       e;
        logic       seen;
        int         k;
        logic [7:0] v;

        RST = 1'b1; req = 1'b0; rs = 1'b0; poll = 1'b0; dIn = 8'h00;
        rd_vals = '{8'h00};
        repeat (3) @(posedge CLK);
        #1;
        check("rst_ctrl", 32'(ctrl), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_busread", 32'(busRead), 32'd0);
        check("rst_rdvalid", 32'(rdValid), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_rddata", 32'(rdData), 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        rd_vals = '{8'h8A};
        start_txn(1'b0, 1'b0);
        wait_idle(200, "idle_bf_read");

        rd_vals = '{8'hC1};
        start_txn(1'b1, 1'b1);
        wait_idle(200, "idle_data_read");

        rd_vals = '{8'h80, 8'h80, 8'h80, 8'h05};
        start_txn(1'b0, 1'b1);
        wait_idle(400, "idle_poll");

        rd_vals = '{8'hFF};
        start_txn(1'b0, 1'b1);
        wait_idle(400, "idle_poll_timeout");

        // Reset in the middle of EHIGH: no model entry, so any rdValid is flagged.
        rd_vals = '{8'h3C};
        @(negedge CLK);
        cur_rs = 1'b0; req = 1'b1; rs = 1'b0; poll = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        req = 1'b0;
        repeat (7) @(negedge CLK);
        check("mid_e_high", 32'(ctrl[CTRL_E]), 32'd1);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("mid_rst_ctrl", 32'(ctrl), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_rddata", 32'(rdData), 32'd0);
        check("mid_rst_rdvalid", 32'(rdValid), 32'd0);
        repeat (30) @(negedge CLK);

        // req while busy is dropped; req held through DONE starts the next read.
        rd_vals = '{8'h5A};
        start_txn(1'b0, 1'b0);
        repeat (4) @(negedge CLK);
        req = 1'b1;
        @(negedge CLK);
        req = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge CLK);
            seen = rdValid;
        end
        check("done_reached", 32'(seen), 32'd1);
        rd_vals = '{8'hA7};
        e = model(1'b1, 1'b0);
        cur_rs = 1'b1; req = 1'b1; rs = 1'b1; poll = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        record_accept(e);
        @(negedge CLK);
        req = 1'b0;
        wait_idle(200, "idle_back_to_back");

        for (int t = 0; t < 16; t++) begin
            k = $urandom_range(0, 5);
            rd_vals = {};
            for (int i = 0; i < k; i++) begin
                v = 8'($urandom) | 8'h80;
                rd_vals.push_back(v);
            end
            v = 8'($urandom) & 8'h7F;
            rd_vals.push_back(v);
            start_txn(1'($urandom), 1'($urandom));
            wait_idle(400, "idle_random");
        end

        repeat (5) @(negedge CLK);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
